wb_evict_buffer: RTL and testbench

- Eviction/writeback buffer directly downstream of the write-back data cache.
- Accepts evicted dirty cache lines and holds them in a small FIFO.
- Drains each line to the memory-side write channel as an incrementing burst, one line outstanding at a time.
- Exposes a line-address snoop so the miss path stalls refills of lines still pending writeback.

---
 rtl/wb_evict_buffer_pkg.sv | 31 +++
 rtl/wb_evict_buffer_if.sv | 43 ++++
 rtl/wb_evict_fifo.sv | 87 ++++++++
 rtl/wb_evict_buffer.sv | 174 +++++++++++++++++
 tb/tb_wb_evict_buffer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_evict_buffer_pkg.sv
// Shared types and helpers for the eviction/writeback buffer.
//   evict_entry_t : one buffered line. The addr/data fields are sized by the
//                   ENTRY_* bounds below, and instances use widths up to those bounds.
//   drain_state_e : drain FSM states.
//   beats()/offs(): beats per line and line-offset bit count.
package wb_evict_pkg;

   localparam int unsigned ENTRY_ADDR_W = 64;
   localparam int unsigned ENTRY_LINE_W = 128;

   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0] addr;
      logic [ENTRY_LINE_W-1:0] data;
   } evict_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AW   = 2'd1,
      W    = 2'd2,
      B    = 2'd3
   } drain_state_e;

   function automatic int unsigned beats(input int unsigned line_w, input int unsigned data_w);
      return line_w / data_w;
   endfunction

   function automatic int unsigned offs(input int unsigned line_w);
      return $clog2(line_w / 8);
   endfunction

endpackage

// File: rtl/wb_evict_buffer_if.sv
// Bus bundle for wb_evict_buffer: cache-side eviction channel, memory-side
// AW/W/B write channels, snoop lookup and the fence empty flag.
// Signal suffixes are from the buffer's point of view.
//   slave  : the buffer itself
//   master : the cache / memory environment around it
interface wb_evict_buffer_if #(
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 64
);
   logic                  evict_valid_i;
   logic                  evict_ready_o;
   logic [ADDR_WIDTH-1:0] evict_addr_i;
   logic [LINE_WIDTH-1:0] evict_data_i;
   logic                  aw_valid_o;
   logic                  aw_ready_i;
   logic [ADDR_WIDTH-1:0] aw_addr_o;
   logic [7:0]            aw_len_o;
   logic                  w_valid_o;
   logic                  w_ready_i;
   logic [DATA_WIDTH-1:0] w_data_o;
   logic                  w_last_o;
   logic                  b_valid_i;
   logic                  b_ready_o;
   logic                  b_error_i;
   logic [ADDR_WIDTH-1:0] lookup_addr_i;
   logic                  lookup_hit_o;
   logic                  empty_o;

   modport slave (
      input  evict_valid_i, evict_addr_i, evict_data_i,
      input  aw_ready_i, w_ready_i, b_valid_i, b_error_i, lookup_addr_i,
      output evict_ready_o, aw_valid_o, aw_addr_o, aw_len_o,
      output w_valid_o, w_data_o, w_last_o, b_ready_o, lookup_hit_o, empty_o
   );

   modport master (
      output evict_valid_i, evict_addr_i, evict_data_i,
      output aw_ready_i, w_ready_i, b_valid_i, b_error_i, lookup_addr_i,
      input  evict_ready_o, aw_valid_o, aw_addr_o, aw_len_o,
      input  w_valid_o, w_data_o, w_last_o, b_ready_o, lookup_hit_o, empty_o
   );
endinterface

// File: rtl/wb_evict_fifo.sv
// Line storage for the eviction buffer: circular FIFO of evict_entry_t with
// count and per-slot occupancy for the snoop.
//   push_i/push_entry_i : write a line at the tail (caller guarantees !full_o)
//   pop_i               : release the head (caller guarantees !empty_o)
//   head_entry_o        : line at the head
//   full_o/empty_o      : count == DEPTH / count == 0
//   occ_o/addr_o        : per-slot valid bit and stored address
module wb_evict_fifo
   import wb_evict_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  evict_entry_t            push_entry_i,
   input  logic                    pop_i,
   output evict_entry_t            head_entry_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [DEPTH-1:0]        occ_o,
   output logic [ENTRY_ADDR_W-1:0] addr_o [DEPTH]
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   evict_entry_t     mem_q [DEPTH];
   evict_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0] occ_q, occ_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      occ_d    = occ_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = push_entry_i;
         occ_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
         occ_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         occ_q    <= occ_d;
      end
   end

   // Line storage is qualified by occ_q, so it needs no reset.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         addr_o[i] = mem_q[i].addr;
      end
   end

   assign head_entry_o = mem_q[rd_ptr_q];
   assign full_o       = (count_q == CNT_W'(DEPTH));
   assign empty_o      = (count_q == '0);
   assign occ_o        = occ_q;

endmodule

// File: rtl/wb_evict_buffer.sv
// Eviction/writeback buffer behind the write-back data cache. Dirty lines are
// queued in wb_evict_fifo and drained one burst at a time on AW/W/B. A line
// snoop flags refills of lines that are still waiting for writeback.
// Ports: clk_i, rst_i (sync, active high), bus (wb_evict_buffer_if.slave).
// Build option WB_EVICT_ERR_CNT_EN adds err_count_o[15:0] (saturating count
// of error responses) and err_clear_i (zeroes it, wins over an increment).
//
// state | meaning
// IDLE  | nothing in flight; start a burst when a line is queued
// AW    | presenting head line address, waiting for aw_ready_i
// W     | streaming head line beats, waiting for w_ready_i
// B     | waiting for the write response; pop the head on b_valid_i
module wb_evict_buffer
   import wb_evict_pkg::*;
#(
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DEPTH      = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
`ifdef WB_EVICT_ERR_CNT_EN
   output logic [15:0]        err_count_o,
   input  logic               err_clear_i,
`endif
   wb_evict_buffer_if.slave   bus
);

   localparam int unsigned BEATS  = beats(LINE_WIDTH, DATA_WIDTH);
   localparam int unsigned OFFS   = offs(LINE_WIDTH);
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   drain_state_e          state_q, state_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;

   evict_entry_t          push_entry;
   evict_entry_t          head_entry;
   logic                  push, pop;
   logic                  fifo_full, fifo_empty;
   logic [DEPTH-1:0]      occ;
   logic [ENTRY_ADDR_W-1:0] entry_addr [DEPTH];
   logic [ADDR_WIDTH-1:0] lookup_line;
   logic [DATA_WIDTH-1:0] beat_data [BEATS];
   logic                  last_beat;
   logic                  b_hs;
   logic                  unused_bits;

   assign unused_bits = ^{bus.evict_addr_i[OFFS-1:0], bus.lookup_addr_i[OFFS-1:0]
`ifndef WB_EVICT_ERR_CNT_EN
                         , bus.b_error_i
`endif
                         };

   // Ready comes only from the registered count, so a same-cycle pop never
   // opens a slot for a push.
   assign bus.evict_ready_o = !fifo_full;
   assign push              = bus.evict_valid_i && !fifo_full;

   always_comb begin
      push_entry = '0;
      push_entry.addr[ADDR_WIDTH-1:OFFS] = bus.evict_addr_i[ADDR_WIDTH-1:OFFS];
      push_entry.data[LINE_WIDTH-1:0]    = bus.evict_data_i;
   end

   wb_evict_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_entry_o (head_entry),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .occ_o        (occ),
      .addr_o       (entry_addr)
   );

   // The head stays in the FIFO until its response, so empty covers in-flight lines.
   assign bus.empty_o = fifo_empty;

   for (genvar g = 0; g < int'(BEATS); g++) begin : g_beat
      assign beat_data[g] = head_entry.data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign last_beat     = (beat_q == BEAT_W'(BEATS - 1));
   assign bus.aw_addr_o = head_entry.addr[ADDR_WIDTH-1:0];
   assign bus.aw_len_o  = 8'(BEATS - 1);
   assign bus.w_data_o  = beat_data[beat_q];
   assign bus.w_last_o  = last_beat;
   assign b_hs          = (state_q == B) && bus.b_valid_i;

   always_comb begin
      state_d        = state_q;
      beat_d         = beat_q;
      pop            = 1'b0;
      bus.aw_valid_o = 1'b0;
      bus.w_valid_o  = 1'b0;
      bus.b_ready_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = AW;
         end
         AW: begin
            bus.aw_valid_o = 1'b1;
            if (bus.aw_ready_i) begin
               state_d = W;
               beat_d  = '0;
            end
         end
         W: begin
            bus.w_valid_o = 1'b1;
            if (bus.w_ready_i) begin
               if (last_beat) state_d = B;
               else           beat_d  = beat_q + BEAT_W'(1);
            end
         end
         B: begin
            bus.b_ready_o = 1'b1;
            if (bus.b_valid_i) begin
               pop     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // Stored addresses already have their offset bits cleared.
   assign lookup_line = {bus.lookup_addr_i[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};

   always_comb begin
      bus.lookup_hit_o = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (occ[i] && (entry_addr[i][ADDR_WIDTH-1:0] == lookup_line)) begin
            bus.lookup_hit_o = 1'b1;
         end
      end
   end

`ifdef WB_EVICT_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clear_i) begin
         err_cnt_d = '0;
      end else if (b_hs && bus.b_error_i && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) err_cnt_q <= '0;
      else       err_cnt_q <= err_cnt_d;
   end

   assign err_count_o = err_cnt_q;
`else
   logic unused_b_hs;
   assign unused_b_hs = b_hs;
`endif

endmodule

// File: tb/tb_wb_evict_buffer.sv
module tb_wb_evict_buffer;

   localparam int LW    = 128;
   localparam int DW    = 64;
   localparam int AWD   = 64;
   localparam int DEPTH = 2;
   localparam int TMO   = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_evict_buffer_if #(.LINE_WIDTH(LW), .DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) bus ();

`ifdef WB_EVICT_ERR_CNT_EN
   logic [15:0] err_count;
   logic        err_clear;
`endif

   wb_evict_buffer #(
      .LINE_WIDTH(LW), .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .DEPTH(DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
`ifdef WB_EVICT_ERR_CNT_EN
      .err_count_o (err_count),
      .err_clear_i (err_clear),
`endif
      .bus         (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // memory-side responder controls (set by tests, applied after each posedge)
   logic       aw_mode = 1'b1;
   int         w_mode  = 1;     // 0 low, 1 high, 2 random with 30% low
   logic       b_en    = 1'b1;
   logic       b_err   = 1'b0;

   // scoreboard
   logic [AWD-1:0] exp_aw_q [$];
   logic [DW:0]    exp_w_q  [$];   // {last, data}

   int aw_cnt = 0;
   int w_cnt  = 0;
   int b_cnt  = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus.aw_ready_i = aw_mode;
         bus.w_ready_i  = (w_mode == 2) ? ($urandom_range(0, 99) >= 30) : (w_mode == 1);
         bus.b_valid_i  = b_en;
         bus.b_error_i  = b_err;
      end
   end

   // monitor: handshakes, payload stability, W-after-AW ordering
   initial begin
      logic           aw_hold, w_hold, aw_done;
      logic [AWD-1:0] hold_addr, exp_a;
      logic [DW-1:0]  hold_data;
      logic           hold_last;
      logic [DW:0]    exp_w;
      aw_hold = 1'b0; w_hold = 1'b0; aw_done = 1'b0;
      hold_addr = '0; hold_data = '0; hold_last = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            aw_hold = 1'b0; w_hold = 1'b0; aw_done = 1'b0;
         end else begin
            if (aw_hold) begin
               checks++;
               if (bus.aw_valid_o !== 1'b1 || bus.aw_addr_o !== hold_addr) begin
                  errors++;
                  $display("FAIL aw_stable valid=%b addr=%h required valid=1 addr=%h", bus.aw_valid_o, bus.aw_addr_o, hold_addr);
               end
            end
            if (w_hold) begin
               checks++;
               if (bus.w_valid_o !== 1'b1 || bus.w_data_o !== hold_data || bus.w_last_o !== hold_last) begin
                  errors++;
                  $display("FAIL w_stable valid=%b data=%h last=%b required valid=1 data=%h last=%b", bus.w_valid_o, bus.w_data_o, bus.w_last_o, hold_data, hold_last);
               end
            end
            if (bus.w_valid_o === 1'b1) begin
               checks++;
               if (!aw_done) begin
                  errors++;
                  $display("FAIL w_before_aw w_valid=1 with no AW handshake");
               end
            end
            if (bus.aw_valid_o === 1'b1 && bus.aw_ready_i === 1'b1) begin
               aw_cnt++;
               aw_done = 1'b1;
               checks++;
               if (exp_aw_q.size() == 0) begin
                  errors++;
                  $display("FAIL aw_unexpected addr=%h required none", bus.aw_addr_o);
               end else begin
                  exp_a = exp_aw_q.pop_front();
                  if (bus.aw_addr_o !== exp_a || bus.aw_len_o !== 8'd1) begin
                     errors++;
                     $display("FAIL aw_payload addr=%h len=%0d required addr=%h len=1", bus.aw_addr_o, bus.aw_len_o, exp_a);
                  end
               end
            end
            if (bus.w_valid_o === 1'b1 && bus.w_ready_i === 1'b1) begin
               w_cnt++;
               checks++;
               if (exp_w_q.size() == 0) begin
                  errors++;
                  $display("FAIL w_unexpected data=%h required none", bus.w_data_o);
               end else begin
                  exp_w = exp_w_q.pop_front();
                  if ({bus.w_last_o, bus.w_data_o} !== exp_w) begin
                     errors++;
                     $display("FAIL w_beat data=%h last=%b required data=%h last=%b", bus.w_data_o, bus.w_last_o, exp_w[DW-1:0], exp_w[DW]);
                  end
               end
            end
            if (bus.b_ready_o === 1'b1 && bus.b_valid_i === 1'b1) begin
               b_cnt++;
               aw_done = 1'b0;
            end
            aw_hold = (bus.aw_valid_o === 1'b1) && (bus.aw_ready_i !== 1'b1);
            hold_addr = bus.aw_addr_o;
            w_hold = (bus.w_valid_o === 1'b1) && (bus.w_ready_i !== 1'b1);
            hold_data = bus.w_data_o;
            hold_last = bus.w_last_o;
         end
      end
   end

   task automatic sample_point();
      @(negedge clk);
      #2;
   endtask

   task automatic push_line(input logic [AWD-1:0] addr, input logic [LW-1:0] data);
      int n;
      logic [AWD-1:0] aligned;
      n = 0;
      @(posedge clk);
      #1;
      bus.evict_valid_i = 1'b1;
      bus.evict_addr_i  = addr;
      bus.evict_data_i  = data;
      sample_point();
      while (bus.evict_ready_o !== 1'b1 && n < TMO) begin
         sample_point();
         n++;
      end
      if (n >= TMO) begin
         checks++; errors++;
         $display("FAIL push_timeout ready=%b required 1", bus.evict_ready_o);
      end else begin
         aligned = addr;
         aligned[3:0] = 4'h0;
         exp_aw_q.push_back(aligned);
         for (int i = 0; i < LW / DW; i++) begin
            exp_w_q.push_back({(i == LW / DW - 1) ? 1'b1 : 1'b0, data[i*DW +: DW]});
         end
      end
      @(posedge clk);
      #1;
      bus.evict_valid_i = 1'b0;
   endtask

   task automatic wait_b(input int b0);
      int n;
      n = 0;
      while (b_cnt == b0 && n < TMO) begin
         sample_point();
         n++;
      end
      if (n >= TMO) begin
         checks++; errors++;
         $display("FAIL b_timeout responses=%0d required more than %0d", b_cnt, b0);
      end
   endtask

   task automatic wait_drained();
      int n;
      n = 0;
      sample_point();
      while (bus.empty_o !== 1'b1 && n < TMO) begin
         sample_point();
         n++;
      end
      checks++;
      if (bus.empty_o !== 1'b1 || exp_w_q.size() != 0 || exp_aw_q.size() != 0) begin
         errors++;
         $display("FAIL drain empty=%b pending_aw=%0d pending_w=%0d required 1 0 0", bus.empty_o, exp_aw_q.size(), exp_w_q.size());
      end
   endtask

   task automatic test_reset();
      bus.evict_valid_i = 1'b0;
      bus.evict_addr_i  = '0;
      bus.evict_data_i  = '0;
      bus.lookup_addr_i = '0;
`ifdef WB_EVICT_ERR_CNT_EN
      err_clear = 1'b0;
`endif
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      sample_point();
      checks++;
      if (bus.aw_valid_o !== 1'b0) begin errors++; $display("FAIL reset_aw_valid got=%b required 0", bus.aw_valid_o); end
      checks++;
      if (bus.w_valid_o !== 1'b0) begin errors++; $display("FAIL reset_w_valid got=%b required 0", bus.w_valid_o); end
      checks++;
      if (bus.b_ready_o !== 1'b0) begin errors++; $display("FAIL reset_b_ready got=%b required 0", bus.b_ready_o); end
      checks++;
      if (bus.lookup_hit_o !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b required 0", bus.lookup_hit_o); end
      checks++;
      if (bus.evict_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required 1", bus.evict_ready_o); end
      checks++;
      if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b required 1", bus.empty_o); end
`ifdef WB_EVICT_ERR_CNT_EN
      checks++;
      if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got=%0d required 0", err_count); end
`endif
   endtask

   task automatic test_basic();
      int b0;
      b0 = b_cnt;
      push_line(64'h8000_0018, {64'hB, 64'hA});
      wait_b(b0);
      sample_point();
      checks++;
      if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL basic_empty got=%b required 1", bus.empty_o); end
      checks++;
      if (aw_cnt != 1 || w_cnt != 2) begin errors++; $display("FAIL basic_counts aw=%0d w=%0d required 1 2", aw_cnt, w_cnt); end
   endtask

   task automatic test_full();
      int b0;
      aw_mode = 1'b0;
      push_line(64'h9000_0000, {64'h1111, 64'h1110});
      push_line(64'h9000_0047, {64'h2221, 64'h2220});
      sample_point();
      checks++;
      if (bus.evict_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b required 0", bus.evict_ready_o); end
      b0 = b_cnt;
      aw_mode = 1'b1;
      wait_b(b0);
      checks++;
      if (bus.evict_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_pop_cycle got=%b required 0", bus.evict_ready_o); end
      sample_point();
      checks++;
      if (bus.evict_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got=%b required 1", bus.evict_ready_o); end
      wait_drained();
   endtask

   task automatic test_snoop();
      int b0, n;
      aw_mode = 1'b0;
      push_line(64'h8000_0040, {64'hC1, 64'hC0});
      bus.lookup_addr_i = 64'h8000_0048;
      #1;
      checks++;
      if (bus.lookup_hit_o !== 1'b1) begin errors++; $display("FAIL snoop_hit_same_line got=%b required 1", bus.lookup_hit_o); end
      bus.lookup_addr_i = 64'h8000_0050;
      #1;
      checks++;
      if (bus.lookup_hit_o !== 1'b0) begin errors++; $display("FAIL snoop_other_line got=%b required 0", bus.lookup_hit_o); end
      bus.lookup_addr_i = 64'h8000_0048;
      b0 = b_cnt;
      aw_mode = 1'b1;
      n = 0;
      do begin
         sample_point();
         n++;
         checks++;
         if (bus.lookup_hit_o !== 1'b1) begin errors++; $display("FAIL snoop_hold got=%b required 1", bus.lookup_hit_o); end
      end while (b_cnt == b0 && n < TMO);
      sample_point();
      checks++;
      if (bus.lookup_hit_o !== 1'b0) begin errors++; $display("FAIL snoop_drop got=%b required 0", bus.lookup_hit_o); end
      wait_drained();
      bus.lookup_addr_i = '0;
   endtask

   task automatic test_wready_random();
      logic [LW-1:0] d;
      w_mode = 2;
      for (int i = 0; i < 4; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         push_line(64'hA000_0000 + 64'(i * 64), d);
      end
      wait_drained();
      w_mode = 1;
   endtask

   task automatic test_reset_mid();
      int n, w0;
      w_mode = 0;
      push_line(64'hB000_0000, {64'hBEEF_0001, 64'hBEEF_0000});
      n = 0;
      while (bus.w_valid_o !== 1'b1 && n < TMO) begin sample_point(); n++; end
      w0 = w_cnt;
      w_mode = 1;
      n = 0;
      while (w_cnt == w0 && n < TMO) begin sample_point(); n++; end
      checks++;
      if (w_cnt != w0 + 1) begin errors++; $display("FAIL rstmid_beat0 beats=%0d required %0d", w_cnt, w0 + 1); end
      w_mode = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      sample_point();
      sample_point();
      checks++;
      if (bus.aw_valid_o !== 1'b0 || bus.w_valid_o !== 1'b0 || bus.b_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_valids aw=%b w=%b b=%b required 0 0 0", bus.aw_valid_o, bus.w_valid_o, bus.b_ready_o);
      end
      checks++;
      if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b required 1", bus.empty_o); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_aw_q.delete();
      exp_w_q.delete();
      w_mode = 1;
      w0 = w_cnt;
      repeat (6) begin
         sample_point();
         checks++;
         if (bus.w_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_beats w_valid=%b required 0", bus.w_valid_o); end
      end
      checks++;
      if (w_cnt != w0) begin errors++; $display("FAIL rstmid_beat_count got=%0d required %0d", w_cnt, w0); end
   endtask

`ifdef WB_EVICT_ERR_CNT_EN
   task automatic test_err_count();
      int n;
      b_err = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_line(64'hC000_0000 + 64'(i * 64), {64'(i), 64'(i + 10)});
      end
      wait_drained();
      sample_point();
      checks++;
      if (err_count !== 16'd3) begin errors++; $display("FAIL err_count got=%0d required 3", err_count); end
      push_line(64'hC000_1000, {64'h5, 64'h4});
      n = 0;
      while (bus.b_ready_o !== 1'b1 && n < TMO) begin sample_point(); n++; end
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
      sample_point();
      checks++;
      if (err_count !== 16'd0) begin errors++; $display("FAIL err_clear_priority got=%0d required 0", err_count); end
      b_err = 1'b0;
      wait_drained();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_snoop();
      test_wready_random();
      test_reset_mid();
`ifdef WB_EVICT_ERR_CNT_EN
      test_err_count();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
